// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
// The grant helper encodes the DM-first policy, including the IF anti-starvation override.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_I    = 2'd1;
  localparam logic [1:0] GNT_D    = 2'd2;

  // DM wins unless IF is waiting and DM has already used up its streak
  function automatic logic [1:0] pick_grant(input logic i_req, input logic d_req,
                                            input logic streak_full);
    logic [1:0] g;
    if (d_req && !(i_req && streak_full)) begin
      g = GNT_D;
    end else if (i_req) begin
      g = GNT_I;
    end else begin
      g = GNT_NONE;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Per-transaction wait counter.
// expired is high in the last cycle allowed to wait for mem_ready.
module mem_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins, count only while below the last wait cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (IF) and load/store (DM).
// One transaction in flight, registered grant and outputs, timeout abort with err pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 15,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_FULL = SW'(MAX_STREAK);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]        gnt_s;
  logic              timer_clr_s;
  logic              timer_en_s;
  logic              timer_expired_s;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr_s),
    .en      (timer_en_s),
    .expired (timer_expired_s)
  );

  // arbitration, request latch and completion handling
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;
    gnt_s       = pick_grant(i_req, d_req, streak_q == STREAK_FULL);
    case (state_q)
      ST_IDLE: begin
        timer_clr_s = 1'b1;
        case (gnt_s)
          GNT_D: begin
            state_d     = ST_BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (i_req && (streak_q != STREAK_FULL)) begin
              streak_d = streak_q + SW'(1);
            end else begin
              streak_d = streak_q;
            end
          end
          GNT_I: begin
            state_d     = ST_BUSY_I;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // a ready arriving in the expiry cycle still counts as a normal completion
        if (mem_ready || timer_expired_s) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = !mem_ready;
          if (state_q == ST_BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : '0;
          end
        end else begin
          timer_en_s = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected grants and completions,
// a negedge monitor pops and compares whenever the DUT starts a memory access or pulses done.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  gnt_t  gq[$];
  done_t dq[$];

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: ready in the ready_lat-th cycle of mem_req (0 = never)
  int          ready_lat = 1;
  int          busy_cnt = 0;
  logic [31:0] resp_data = 32'h0;
  assign mem_rdata = resp_data;

  always @(posedge clk) begin
    #1;
    if (mem_req === 1'b1) begin
      busy_cnt  = busy_cnt + 1;
      mem_ready = (ready_lat != 0) && (busy_cnt == ready_lat);
    end else begin
      busy_cnt  = 0;
      mem_ready = 1'b0;
    end
  end

  // monitor: compare grants and completions against the scoreboard queues
  logic        req_prev = 1'b0;
  logic [31:0] addr_prev = 32'h0;
  gnt_t        g;
  done_t       e;
  logic [31:0] got_rdata;

  always @(negedge clk) begin
    if (mem_req === 1'b1 && req_prev !== 1'b1) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected addr=%h we=%b, required no grant", mem_addr, mem_we);
      end else begin
        g = gq.pop_front();
        if (mem_addr !== g.addr || mem_we !== g.we || (g.we && mem_wdata !== g.wdata)) begin
          errors++;
          $display("FAIL grant addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                   mem_addr, mem_we, mem_wdata, g.addr, g.we, g.wdata);
        end
      end
    end else if (mem_req === 1'b1 && mem_addr !== addr_prev) begin
      checks++;
      errors++;
      $display("FAIL addr_stable addr=%h, required %h", mem_addr, addr_prev);
    end
    if (i_done === 1'b1 || d_done === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected i_done=%b d_done=%b, required none", i_done, d_done);
      end else begin
        e = dq.pop_front();
        got_rdata = e.is_d ? d_rdata : i_rdata;
        if (d_done !== e.is_d || i_done !== !e.is_d || got_rdata !== e.rdata || err !== e.err) begin
          errors++;
          $display("FAIL done i_done=%b d_done=%b rdata=%h err=%b, required d_side=%b rdata=%h err=%b",
                   i_done, d_done, got_rdata, err, e.is_d, e.rdata, e.err);
        end
      end
    end else if (err === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL err_alone err=%b, required 0 without a done pulse", err);
    end
    req_prev  = mem_req;
    addr_prev = mem_addr;
  end

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // wait for a done pulse of one side; returns the cycle it was seen in
  task automatic wait_done(input bit is_d, output int dc);
    bit seen;
    seen = 1'b0;
    dc = -1;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk);
      #2;
      if ((is_d && d_done === 1'b1) || (!is_d && i_done === 1'b1)) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout d_side=%0d got no pulse, required one", is_d);
    end
  endtask

  task automatic req_if(input logic [31:0] a, output int dc);
    i_addr = a;
    i_req  = 1'b1;
    wait_done(1'b0, dc);
    i_req  = 1'b0;
  endtask

  task automatic req_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output int dc);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    wait_done(1'b1, dc);
    d_req   = 1'b0;
  endtask

  int c0, dc, dc_i, dc_d;

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({mem_req, mem_we, i_done, d_done, err} !== 5'b00000 ||
        {mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs ctl=%b addr=%h wdata=%h i_rdata=%h d_rdata=%h, required all 0",
               {mem_req, mem_we, i_done, d_done, err}, mem_addr, mem_wdata, i_rdata, d_rdata);
    end
    reset = 1'b0;

    // IF alone, minimum latency
    ready_lat = 1; resp_data = 32'h8C01_0004;
    gq.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0});
    dq.push_back('{is_d: 1'b0, rdata: 32'h8C01_0004, err: 1'b0});
    c0 = cyc;
    req_if(32'h40, dc);
    check_int("if_latency", dc, c0 + 2);

    // IF held while DM streams loads: fifth grant must go to IF
    resp_data = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      gq.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
      dq.push_back('{is_d: 1'b1, rdata: 32'h1234_5678, err: 1'b0});
    end
    gq.push_back('{addr: 32'h80, we: 1'b0, wdata: 32'h0});
    dq.push_back('{is_d: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
    c0 = cyc;
    d_we = 1'b0; d_addr = 32'h200; d_req = 1'b1;
    i_addr = 32'h80; i_req = 1'b1;
    wait_done(1'b0, dc);
    i_req = 1'b0; d_req = 1'b0;
    check_int("streak_if_done", dc, c0 + 10);

    // simultaneous requests: DM store first (d_rdata forced 0), then IF
    resp_data = 32'h0BAD_F00D;
    gq.push_back('{addr: 32'h100, we: 1'b1, wdata: 32'hCAFE});
    gq.push_back('{addr: 32'h44, we: 1'b0, wdata: 32'h0});
    dq.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b0});
    dq.push_back('{is_d: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
    c0 = cyc;
    fork
      req_dm(1'b1, 32'h100, 32'hCAFE, dc_d);
      req_if(32'h44, dc_i);
    join
    check_int("both_dm_done", dc_d, c0 + 2);
    check_int("both_if_done", dc_i, c0 + 4);

    // memory never ready: abort after 15 waiting cycles
    ready_lat = 0; resp_data = 32'h7777_7777;
    gq.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0});
    dq.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b1});
    c0 = cyc;
    req_dm(1'b0, 32'h300, 32'h0, dc);
    check_int("timeout_latency", dc, c0 + 16);

    // ready exactly in the last allowed cycle: normal completion
    ready_lat = 15; resp_data = 32'hDEAD_BEEF;
    gq.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0});
    dq.push_back('{is_d: 1'b1, rdata: 32'hDEAD_BEEF, err: 1'b0});
    c0 = cyc;
    req_dm(1'b0, 32'h500, 32'h0, dc);
    check_int("ready_at_timeout_latency", dc, c0 + 16);

    // DM drops its request after one cycle: transaction still completes
    ready_lat = 3; resp_data = 32'h0F0F_0F0F;
    gq.push_back('{addr: 32'h600, we: 1'b0, wdata: 32'h0});
    dq.push_back('{is_d: 1'b1, rdata: 32'h0F0F_0F0F, err: 1'b0});
    c0 = cyc;
    d_we = 1'b0; d_addr = 32'h600; d_req = 1'b1;
    @(posedge clk);
    #1;
    d_req = 1'b0;
    wait_done(1'b1, dc);
    check_int("drop_req_latency", dc, c0 + 4);

    // reset two cycles into a load: request drops, no done
    ready_lat = 0;
    gq.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0});
    d_we = 1'b0; d_addr = 32'h400; d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mem_req, d_done, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid mem_req=%b d_done=%b err=%b, required 000", mem_req, d_done, err);
    end
    reset = 1'b0;
    ready_lat = 1; resp_data = 32'hA5A5_5A5A;
    gq.push_back('{addr: 32'h48, we: 1'b0, wdata: 32'h0});
    dq.push_back('{is_d: 1'b0, rdata: 32'hA5A5_5A5A, err: 1'b0});
    c0 = cyc;
    req_if(32'h48, dc);
    check_int("after_reset_if_latency", dc, c0 + 2);

    repeat (4) @(posedge clk);
    #2;
    check_int("grant_queue_left", gq.size(), 0);
    check_int("done_queue_left", dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
